// File: rtl/cpu_defs.sv
// ============================================================================
// Module   : cpu_defs (package)
// Purpose  : Shared operand, operation and store-FSM state types.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_defs;

    typedef logic [31:0] word_t;

    typedef enum logic [2:0] {
        OP_NOP = 3'd0,
        OP_SB  = 3'd1,
        OP_SH  = 3'd2,
        OP_SW  = 3'd3,
        OP_LB  = 3'd4,
        OP_LH  = 3'd5,
        OP_LW  = 3'd6,
        OP_ADD = 3'd7
    } oper_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_BEAT1 = 2'd2,
        ST_FIN   = 2'd3
    } state_t;

    // Unshifted byte mask for a store; zero marks a non-store operation.
    function automatic logic [3:0] store_lane_mask(input oper_t op);
        logic [3:0] m;
        case (op)
            OP_SB:   m = 4'b0001;
            OP_SH:   m = 4'b0011;
            OP_SW:   m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

`default_nettype wire

// File: rtl/store_lane_align.sv
// ============================================================================
// Module   : store_lane_align
// Purpose  : Builds the 8-lane byte enables and 64-bit lane-positioned data.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module store_lane_align
    import cpu_defs::*;
(
    input  oper_t       i_op,
    input  logic [1:0]  i_off,
    input  word_t       i_data,
    output logic [7:0]  o_be8,
    output logic [63:0] o_data64,
    output logic        o_is_store
);

    logic [3:0] w_mask;
    word_t      w_trunc;

    always_comb begin
        w_mask     = store_lane_mask(i_op);
        o_is_store = |w_mask;
        w_trunc    = i_data & {{8{w_mask[3]}}, {8{w_mask[2]}},
                               {8{w_mask[1]}}, {8{w_mask[0]}}};
        o_be8      = {4'b0000, w_mask} << i_off;
        o_data64   = {32'h0000_0000, w_trunc} << {i_off, 3'b000};
    end

endmodule

`default_nettype wire

// File: rtl/mem_store_unit.sv
// ============================================================================
// Module   : mem_store_unit
// Purpose  : Store unit issuing one or two aligned write beats per request.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_store_unit
    import cpu_defs::*;
#(
    parameter bit ALLOW_SPLIT = 1'b1
)(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  oper_t      req_op,
    input  word_t      req_addr,
    input  word_t      req_data,
    output logic       bus_valid,
    input  logic       bus_ready,
    output word_t      bus_addr,
    output word_t      bus_wdata,
    output logic [3:0] bus_be,
    output logic       done,
    output logic       fault
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_live;
    word_t       r_addr;
    logic [7:0]  r_be;
    logic [63:0] r_wdata;
    logic        r_fault;

    logic [7:0]  w_be8;
    logic [63:0] w_data64;
    logic        w_is_store;
    logic        w_accept;
    logic        w_fault;

    store_lane_align u_align (
        .i_op       (req_op),
        .i_off      (req_addr[1:0]),
        .i_data     (req_data),
        .o_be8      (w_be8),
        .o_data64   (w_data64),
        .o_is_store (w_is_store)
    );

    // r_live keeps req_ready low during reset and raises it on the first edge after.
    assign req_ready = (r_state == ST_IDLE) && r_live;
    assign w_accept  = req_valid && req_ready;
    assign w_fault   = w_is_store && (|w_be8[7:4]) && (ALLOW_SPLIT == 1'b0);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (!w_is_store || w_fault) begin
                        w_state_nxt = ST_FIN;
                    end else begin
                        w_state_nxt = ST_BEAT0;
                    end
                end
            end
            ST_BEAT0: begin
                if (bus_ready) begin
                    w_state_nxt = (|r_be[7:4]) ? ST_BEAT1 : ST_FIN;
                end
            end
            ST_BEAT1: begin
                if (bus_ready) begin
                    w_state_nxt = ST_FIN;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        bus_valid = 1'b0;
        bus_addr  = '0;
        bus_wdata = '0;
        bus_be    = 4'b0000;
        done      = 1'b0;
        fault     = 1'b0;
        case (r_state)
            ST_BEAT0: begin
                bus_valid = 1'b1;
                bus_addr  = r_addr;
                bus_wdata = r_wdata[31:0];
                bus_be    = r_be[3:0];
            end
            ST_BEAT1: begin
                bus_valid = 1'b1;
                bus_addr  = r_addr + 32'd4;
                bus_wdata = r_wdata[63:32];
                bus_be    = r_be[7:4];
            end
            ST_FIN: begin
                done  = 1'b1;
                fault = r_fault;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_live  <= 1'b0;
            r_addr  <= '0;
            r_be    <= '0;
            r_wdata <= '0;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_live  <= 1'b1;
            if (w_accept) begin
                r_addr  <= {req_addr[31:2], 2'b00};
                r_be    <= w_be8;
                r_wdata <= w_data64;
                r_fault <= w_fault;
            end
        end
    end

endmodule

`default_nettype wire
